spi_driver: RTL and testbench
=============================

SPI_DRIVER -- requirements
Module: spi_driver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, giving the SPI clock half-period in clk cycles (legal range 1-255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port command_read, input, 1 bit: one-cycle strobe that latches Spi_rw as the command.
REQ-005 The block SHALL have port Spi_rw, input, 2 bits: the command opcode; 01 = write, 10 = read, 00/11 = no-op.
REQ-006 The block SHALL have port tx_read, input, 1 bit: one-cycle strobe that pushes Spi_tx_reg into the TX buffer.
REQ-007 The block SHALL have port Spi_tx_reg, input, 8 bits: the TX byte; the first byte is control bit plus 7-bit address, the second is write data.
REQ-008 The block SHALL have port rx_read, input, 1 bit: one-cycle strobe that acknowledges the RX byte and clears Spi_rx_reg to 0x00.
REQ-009 The block SHALL have port Spi_rx_reg, output, 8 bits: the last byte read.
REQ-010 The block SHALL have port busy, output, 1 bit: high from command acceptance until the return to IDLE.
REQ-011 The block SHALL have port cur_state, output, 4 bits: the FSM state encoding.
REQ-012 The block SHALL have ports SPI_MISO (input, 1 bit) and SPI_MOSI (output, 1 bit).
REQ-013 The block SHALL have ports SPI_CLK_LINE (output, 1 bit, idle low) and SPI_EN (output, 1 bit, active-high chip enable).

Function
REQ-014 The TX buffer SHALL be a 2-entry FIFO; a tx_read strobe while the FIFO is full SHALL drop the byte; tx_read and command_read in the same cycle SHALL both take effect.
REQ-015 command_read SHALL be accepted only in IDLE; if accepted with opcode 00/11 the block SHALL stay in IDLE; while busy, command_read SHALL be ignored.
REQ-016 The FSM SHALL have states IDLE=0, LOAD=1, EN_SETUP=2, SHIFT_ADDR=3, SHIFT_WDATA=4, SHIFT_RDATA=5, EN_HOLD=6, DONE=7.
REQ-017 IDLE->LOAD on an accepted 01/10 command.
REQ-018 LOAD SHALL wait until the FIFO holds 2 bytes (write) or 1 byte (read), then go to EN_SETUP.
REQ-019 EN_SETUP SHALL raise SPI_EN for one half-period before the first SPI_CLK_LINE rising edge.
REQ-020 SHIFT_ADDR SHALL shift FIFO byte 0 MSB-first, then go to SHIFT_WDATA (write) or SHIFT_RDATA (read).
REQ-021 SHIFT_WDATA SHALL shift FIFO byte 1 MSB-first.
REQ-022 SHIFT_RDATA SHALL hold MOSI at 0 and sample MISO on each rising edge, MSB first.
REQ-023 EN_HOLD SHALL keep SPI_EN high for one half-period after the last falling edge, then lower it.
REQ-024 DONE SHALL last one cycle, load Spi_rx_reg (reads only), clear busy, and return to IDLE.
REQ-025 MOSI SHALL change on the SPI_CLK_LINE falling edge (the first bit at EN_SETUP) and be sampled on rising edges; each bit SHALL last 2*CLK_DIV clk cycles, so a frame is 16 SPI clocks.
REQ-026 The opcode byte SHALL be transmitted unmodified; the block SHALL NOT alter bit 7.
REQ-027 rx_read SHALL have no effect on the FSM; a read completing in the same cycle as rx_read SHALL win, and Spi_rx_reg SHALL take the new byte.
REQ-028 FIFO entries SHALL be popped only when their shift phase completes.

Reset
REQ-029 With rst_n low, the block SHALL force state IDLE, busy=0, SPI_EN=0, SPI_CLK_LINE=0, SPI_MOSI=0, Spi_rx_reg=0x00, FIFO empty, and no pending command.
REQ-030 Assertion of rst_n mid-frame SHALL abort the frame immediately, without completing the frame.

Configuration
REQ-031 With macro SPI_DRIVER_LOOPBACK_EN defined, the receive path SHALL sample SPI_MOSI internally instead of SPI_MISO; without it, SPI_MISO is used and there is no loopback logic.

Structure
REQ-032 Package spi_driver_pkg SHALL hold the state enum (4-bit), the opcode constants (WRITE=2'b01, READ=2'b10), and the frame length constants.
REQ-033 Sub-module spi_clk_gen SHALL produce the SPI_CLK_LINE and the rise/fall enable pulses from CLK_DIV.

Verification
REQ-034 Write: Spi_rw=01 + command_read, then push 0x9E and 0x3C -> MOSI sequence is 1001111000111100; 16 SPI clocks of 40 ns at CLK_DIV=2 and a 10 ns clk; busy falls after EN_HOLD.
REQ-035 Read: Spi_rw=10, push 0x1E, MISO drives 0xA5 -> Spi_rx_reg=0xA5 at DONE; rx_read -> 0x00.
REQ-036 Command accepted with an empty FIFO -> the block waits in LOAD (cur_state=1); a byte pushed 50 cycles later -> the frame starts.
REQ-037 Reset mid-SHIFT_WDATA -> all outputs return to reset values within the same cycle; the next write frame is correct.
REQ-038 command_read while busy, and a third tx_read while the FIFO is full -> both are ignored, and the frame data is unchanged.
REQ-039 With SPI_DRIVER_LOOPBACK_EN, a read after pushing 0x5A -> Spi_rx_reg=0x00, because MOSI is held at 0 during SHIFT_RDATA.

Source files
------------

// File: rtl/spi_driver_pkg.sv
// rtl/spi_driver_pkg.sv - state encoding, opcodes and frame lengths for spi_driver
package spi_driver_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_LOAD        = 4'd1,
        ST_EN_SETUP    = 4'd2,
        ST_SHIFT_ADDR  = 4'd3,
        ST_SHIFT_WDATA = 4'd4,
        ST_SHIFT_RDATA = 4'd5,
        ST_EN_HOLD     = 4'd6,
        ST_DONE        = 4'd7
    } spi_state_e;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam int ADDR_BITS  = 8;
    localparam int FRAME_BITS = 16;

    // Bit counter values on the falling edge that ends each phase
    localparam logic [3:0] ADDR_LAST  = 4'(ADDR_BITS - 1);
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SPI clock line and half-period edge pulses from CLK_DIV
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic sclk_en,
    output logic sclk,
    output logic tick,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;

    // tick marks the last clk of a half-period; rise/fall say which edge it produces
    assign tick = run && (cnt == 8'(CLK_DIV - 1));
    assign rise = tick && sclk_en && !sclk;
    assign fall = tick && sclk_en && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 8'd0;
            sclk <= 1'b0;
        end else if (!run) begin
            cnt  <= 8'd0;
            sclk <= 1'b0;
        end else begin
            cnt <= tick ? 8'd0 : cnt + 8'd1;
            if (rise || fall) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/spi_driver.sv
// rtl/spi_driver.sv - SPI master frame driver; SPI_DRIVER_LOOPBACK_EN samples MOSI instead of MISO
module spi_driver
    import spi_driver_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       command_read,
    input  logic [1:0] Spi_rw,
    input  logic       tx_read,
    input  logic [7:0] Spi_tx_reg,
    input  logic       rx_read,
    output logic [7:0] Spi_rx_reg,
    output logic       busy,
    output logic [3:0] cur_state,
    input  logic       SPI_MISO,
    output logic       SPI_MOSI,
    output logic       SPI_CLK_LINE,
    output logic       SPI_EN
);

    localparam logic [3:0] IDLE        = ST_IDLE;
    localparam logic [3:0] LOAD        = ST_LOAD;
    localparam logic [3:0] EN_SETUP    = ST_EN_SETUP;
    localparam logic [3:0] SHIFT_ADDR  = ST_SHIFT_ADDR;
    localparam logic [3:0] SHIFT_WDATA = ST_SHIFT_WDATA;
    localparam logic [3:0] SHIFT_RDATA = ST_SHIFT_RDATA;
    localparam logic [3:0] EN_HOLD     = ST_EN_HOLD;
    localparam logic [3:0] DONE        = ST_DONE;

    logic [3:0] state;
    logic       is_read;
    logic [7:0] fifo_mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] fifo_cnt;
    logic [7:0] head;
    logic [7:0] second;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [3:0] bit_cnt;
    logic       run;
    logic       sclk_en;
    logic       tick;
    logic       rise;
    logic       fall;
    logic       push;
    logic       pop;
    logic       miso_src;

`ifdef SPI_DRIVER_LOOPBACK_EN
    assign miso_src = SPI_MOSI;
`else
    assign miso_src = SPI_MISO;
`endif

    assign busy      = (state != IDLE);
    assign cur_state = state;
    assign run       = (state >= EN_SETUP) && (state <= EN_HOLD);
    assign sclk_en   = (state >= EN_SETUP) && (state <= SHIFT_RDATA);
    assign head      = fifo_mem[rd_ptr];
    assign second    = fifo_mem[~rd_ptr];
    assign push      = tx_read && (fifo_cnt != 2'd2);
    // Entries stay in the FIFO until the phase that shifts them has finished
    assign pop       = fall && (((state == SHIFT_ADDR) && (bit_cnt == ADDR_LAST)) ||
                                ((state == SHIFT_WDATA) && (bit_cnt == FRAME_LAST)));

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .sclk_en (sclk_en),
        .sclk    (SPI_CLK_LINE),
        .tick    (tick),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= Spi_tx_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_read    <= 1'b0;
            SPI_EN     <= 1'b0;
            SPI_MOSI   <= 1'b0;
            tx_sh      <= 8'h00;
            rx_sh      <= 8'h00;
            bit_cnt    <= 4'd0;
            Spi_rx_reg <= 8'h00;
        end else begin
            if (rx_read) begin
                Spi_rx_reg <= 8'h00;
            end
            case (state)
                IDLE: begin
                    if (command_read && ((Spi_rw == OP_WRITE) || (Spi_rw == OP_READ))) begin
                        is_read <= (Spi_rw == OP_READ);
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (fifo_cnt >= (is_read ? 2'd1 : 2'd2)) begin
                        state    <= EN_SETUP;
                        SPI_EN   <= 1'b1;
                        SPI_MOSI <= head[7];
                        tx_sh    <= {head[6:0], 1'b0};
                        bit_cnt  <= 4'd0;
                    end
                end
                EN_SETUP: begin
                    if (rise) begin
                        state <= SHIFT_ADDR;
                    end
                end
                SHIFT_ADDR, SHIFT_WDATA, SHIFT_RDATA: begin
                    if (rise && (state == SHIFT_RDATA)) begin
                        rx_sh <= {rx_sh[6:0], miso_src};
                    end
                    if (fall) begin
                        bit_cnt  <= bit_cnt + 4'd1;
                        SPI_MOSI <= tx_sh[7];
                        tx_sh    <= {tx_sh[6:0], 1'b0};
                        if ((state == SHIFT_ADDR) && (bit_cnt == ADDR_LAST)) begin
                            if (is_read) begin
                                state    <= SHIFT_RDATA;
                                SPI_MOSI <= 1'b0;
                                tx_sh    <= 8'h00;
                            end else begin
                                state    <= SHIFT_WDATA;
                                SPI_MOSI <= second[7];
                                tx_sh    <= {second[6:0], 1'b0};
                            end
                        end else if (bit_cnt == FRAME_LAST) begin
                            state    <= EN_HOLD;
                            SPI_MOSI <= 1'b0;
                        end
                    end
                end
                EN_HOLD: begin
                    if (tick) begin
                        SPI_EN <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // Placed after the rx_read clear so a completing read wins
                    if (is_read) begin
                        Spi_rx_reg <= rx_sh;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_driver.sv
// tb/tb_spi_driver.sv - self-checking bench for spi_driver
module tb_spi_driver;

    localparam int CLK_DIV = 2;
    localparam int HALF    = CLK_DIV * 10;

    typedef struct packed {
        logic        rd;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  miso;
        logic [15:0] mosi;
        logic [7:0]  rx;
    } vec_t;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       command_read = 1'b0;
    logic [1:0] Spi_rw       = 2'b00;
    logic       tx_read      = 1'b0;
    logic [7:0] Spi_tx_reg   = 8'h00;
    logic       rx_read      = 1'b0;
    logic       SPI_MISO     = 1'b0;
    logic [7:0] Spi_rx_reg;
    logic       busy;
    logic [3:0] cur_state;
    logic       SPI_MOSI;
    logic       SPI_CLK_LINE;
    logic       SPI_EN;

    int checks = 0;
    int errors = 0;

    logic        en_q      = 1'b0;
    logic        sclk_q    = 1'b0;
    int          rise_cnt  = 0;
    logic [15:0] mosi_cap  = 16'h0000;
    logic [7:0]  miso_byte = 8'h00;
    time         t_en_rise, t_en_fall, t_r1, t_r2, t_last_fall;

    vec_t vecs [5];

    spi_driver #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .command_read (command_read),
        .Spi_rw       (Spi_rw),
        .tx_read      (tx_read),
        .Spi_tx_reg   (Spi_tx_reg),
        .rx_read      (rx_read),
        .Spi_rx_reg   (Spi_rx_reg),
        .busy         (busy),
        .cur_state    (cur_state),
        .SPI_MISO     (SPI_MISO),
        .SPI_MOSI     (SPI_MOSI),
        .SPI_CLK_LINE (SPI_CLK_LINE),
        .SPI_EN       (SPI_EN)
    );

    always #5 clk = ~clk;

    // Slave model: captures MOSI on rising edges, drives the read byte after the address byte
    always @(SPI_EN or SPI_CLK_LINE) begin
        if (SPI_EN && !en_q) begin
            rise_cnt  = 0;
            mosi_cap  = 16'h0000;
            t_en_rise = $time;
        end
        if (!SPI_EN && en_q) begin
            t_en_fall = $time;
        end
        if (SPI_CLK_LINE && !sclk_q) begin
            rise_cnt = rise_cnt + 1;
            mosi_cap = {mosi_cap[14:0], SPI_MOSI};
            if (rise_cnt == 1) t_r1 = $time;
            if (rise_cnt == 2) t_r2 = $time;
        end
        if (!SPI_CLK_LINE && sclk_q) begin
            t_last_fall = $time;
            if (rise_cnt >= 8 && rise_cnt < 16) begin
                SPI_MISO = miso_byte[3'(15 - rise_cnt)];
            end
        end
        en_q   = SPI_EN;
        sclk_q = SPI_CLK_LINE;
    end

    function automatic logic [7:0] rx_exp(input logic [7:0] m);
`ifdef SPI_DRIVER_LOOPBACK_EN
        return 8'h00;
`else
        return m;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cmd(input logic [1:0] op);
        @(negedge clk);
        Spi_rw       = op;
        command_read = 1'b1;
        @(negedge clk);
        command_read = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        tx_read    = 1'b1;
        Spi_tx_reg = b;
        @(negedge clk);
        tx_read    = 1'b0;
    endtask

    task automatic pulse_rx_read();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("frame_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic wait_state(input logic [3:0] s, input string nm);
        for (int i = 0; i < 500; i++) begin
            if (cur_state == s) break;
            @(negedge clk);
        end
        check(nm, 32'(cur_state), 32'(s));
    endtask

    task automatic run_frame(input vec_t v, input string nm);
        miso_byte = v.miso;
        start_cmd(v.rd ? 2'b10 : 2'b01);
        check({nm, "_busy_on"}, 32'(busy), 32'd1);
        check({nm, "_load"}, 32'(cur_state), 32'd1);
        push(v.b0);
        if (!v.rd) push(v.b1);
        wait_idle();
        check({nm, "_mosi"}, 32'(mosi_cap), 32'(v.mosi));
        check({nm, "_sclks"}, 32'(rise_cnt), 32'd16);
        check({nm, "_rx"}, 32'(Spi_rx_reg), 32'(v.rx));
        check({nm, "_en_off"}, 32'(SPI_EN), 32'd0);
        check({nm, "_setup"}, 32'(t_r1 - t_en_rise), 32'(HALF));
        check({nm, "_period"}, 32'(t_r2 - t_r1), 32'(2 * HALF));
        check({nm, "_hold"}, 32'(t_en_fall - t_last_fall), 32'(HALF));
        pulse_rx_read();
        check({nm, "_rx_clr"}, 32'(Spi_rx_reg), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rd: 1'b0, b0: 8'h9E, b1: 8'h3C, miso: 8'h00, mosi: 16'h9E3C, rx: 8'h00};
        vecs[1] = '{rd: 1'b1, b0: 8'h1E, b1: 8'h00, miso: 8'hA5, mosi: 16'h1E00, rx: rx_exp(8'hA5)};
        vecs[2] = '{rd: 1'b0, b0: 8'h80, b1: 8'hFF, miso: 8'h00, mosi: 16'h80FF, rx: 8'h00};
        vecs[3] = '{rd: 1'b1, b0: 8'h5A, b1: 8'h00, miso: 8'h3C, mosi: 16'h5A00, rx: rx_exp(8'h3C)};
        vecs[4] = '{rd: 1'b0, b0: 8'h01, b1: 8'h80, miso: 8'h00, mosi: 16'h0180, rx: 8'h00};

        step(3);
        check("rst_state", 32'(cur_state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(SPI_EN), 32'd0);
        check("rst_sclk", 32'(SPI_CLK_LINE), 32'd0);
        check("rst_mosi", 32'(SPI_MOSI), 32'd0);
        check("rst_rx", 32'(Spi_rx_reg), 32'd0);
        rst_n = 1'b1;
        step(2);

        start_cmd(2'b00);
        check("noop00_state", 32'(cur_state), 32'd0);
        start_cmd(2'b11);
        check("noop11_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        miso_byte = 8'hC3;
        start_cmd(2'b10);
        step(50);
        check("load_wait_state", 32'(cur_state), 32'd1);
        check("load_wait_en", 32'(SPI_EN), 32'd0);
        push(8'h1E);
        step(3);
        check("load_start_en", 32'(SPI_EN), 32'd1);
        wait_idle();
        check("load_mosi", 32'(mosi_cap), 32'h1E00);
        check("load_rx", 32'(Spi_rx_reg), 32'(rx_exp(8'hC3)));
        pulse_rx_read();

        start_cmd(2'b01);
        push(8'h9E);
        push(8'h3C);
        push(8'h55);
        step(10);
        start_cmd(2'b10);
        wait_idle();
        check("busy_ign_mosi", 32'(mosi_cap), 32'h9E3C);
        check("busy_ign_state", 32'(cur_state), 32'd0);
        start_cmd(2'b10);
        step(5);
        check("drop_fifo_empty", 32'(cur_state), 32'd1);
        miso_byte = 8'h00;
        push(8'hAA);
        wait_idle();
        check("drop_next_mosi", 32'(mosi_cap), 32'hAA00);

        miso_byte = 8'h66;
        start_cmd(2'b10);
        push(8'h1E);
        wait_state(4'd7, "done_reached");
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
        check("done_wins_rx", 32'(Spi_rx_reg), 32'(rx_exp(8'h66)));
        pulse_rx_read();
        check("rx_ack_clr", 32'(Spi_rx_reg), 32'd0);

        start_cmd(2'b01);
        push(8'hF0);
        push(8'h0F);
        wait_state(4'd4, "wdata_reached");
        step(2);
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(cur_state), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_en", 32'(SPI_EN), 32'd0);
        check("midrst_sclk", 32'(SPI_CLK_LINE), 32'd0);
        check("midrst_mosi", 32'(SPI_MOSI), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        run_frame('{rd: 1'b0, b0: 8'hC5, b1: 8'h5A, miso: 8'h00, mosi: 16'hC55A, rx: 8'h00}, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
